// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and imem.
// The fetch side holds imem_addr stable from request until acknowledge.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC, one-entry skid buffer for IF/ID stalls,
// and redirect/exception handling that never withdraws an outstanding memory request.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               exc,
    fetch_ctrl_if.master       imem,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_instr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pending_r;
    logic [31:0] skid_pc_r;
    logic [31:0] skid_instr_r;
    logic        req_r;
    logic        valid_r;
    logic [31:0] out_pc_r;
    logic [31:0] out_instr_r;

    logic        flush_s;
    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign flush_s  = exc | redirect;
    assign pc_inc_s = pc_r + 32'd4;

    // Redirect target selection; an exception overrides any branch target.
    always_comb begin
        target_s = word_align(redirect_pc);
        if (exc) begin
            target_s = word_align(EXC_VEC);
        end else begin
            target_s = word_align(redirect_pc);
        end
    end

    // Fetch FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            pending_r    <= 32'h0000_0000;
            skid_pc_r    <= 32'h0000_0000;
            skid_instr_r <= 32'h0000_0000;
            req_r        <= 1'b0;
            valid_r      <= 1'b0;
            out_pc_r     <= 32'h0000_0000;
            out_instr_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                    valid_r <= 1'b0;
                end

                FETCH: begin
                    if (flush_s) begin
                        valid_r <= 1'b0;
                        if (imem.imem_ack) begin
                            pc_r <= target_s;
                        end else begin
                            // Request cannot be withdrawn: keep pc on the bus and park the target.
                            pending_r <= target_s;
                            state_r   <= DRAIN;
                        end
                    end else if (imem.imem_ack) begin
                        pc_r <= pc_inc_s;
                        if (!stall) begin
                            valid_r     <= 1'b1;
                            out_pc_r    <= pc_r;
                            out_instr_r <= imem.imem_rdata;
                        end else begin
                            skid_pc_r    <= pc_r;
                            skid_instr_r <= imem.imem_rdata;
                            state_r      <= HOLD;
                            req_r        <= 1'b0;
                        end
                    end else if (!stall) begin
                        valid_r <= 1'b0;
                    end
                end

                HOLD: begin
                    if (flush_s) begin
                        valid_r <= 1'b0;
                        pc_r    <= target_s;
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                    end else if (!stall) begin
                        valid_r     <= 1'b1;
                        out_pc_r    <= skid_pc_r;
                        out_instr_r <= skid_instr_r;
                        state_r     <= FETCH;
                        req_r       <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (flush_s) begin
                        valid_r <= 1'b0;
                    end
                    if (imem.imem_ack) begin
                        // A redirect arriving together with the ack supersedes the parked one.
                        pc_r    <= flush_s ? target_s : pending_r;
                        state_r <= FETCH;
                    end else if (flush_s) begin
                        pending_r <= target_s;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign if_valid       = valid_r;
    assign if_pc          = out_pc_r;
    assign if_instr       = out_instr_r;

endmodule
